fpa_share_arb: RTL and testbench

- Round-robin arbiter/sequencer that shares one fp_add_32 instance between N requesters.
- Latches the granted operands and applies optional subtraction by flipping the sign bit of operand B.
- Drives the adder's level handshake (add held, wait for ready, drop add) and returns the sum to the granted requester with a one-cycle response strobe.
- Sits between the FP clients and the shared adder in the FP datapath.

---
 rtl/fpa_arb_pkg.sv | 23 ++
 rtl/fpa_rr_pick.sv | 37 +++
 rtl/fpa_share_arb.sv | 213 +++++++++++++++++++++
 tb/tb_fpa_share_arb.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpa_arb_pkg.sv
// Shared constants for the FP adder arbiter: FSM encoding, flush length,
// IEEE-754 single constants and the operand-B sign helper.
package fpa_arb_pkg;

   localparam logic [2:0] ST_FLUSH   = 3'd0;
   localparam logic [2:0] ST_IDLE    = 3'd1;
   localparam logic [2:0] ST_ISSUE   = 3'd2;
   localparam logic [2:0] ST_WAIT    = 3'd3;
   localparam logic [2:0] ST_RELEASE = 3'd4;

   localparam int          FLUSH_CYC   = 7;
   localparam logic [31:0] FP_QNAN     = 32'h7FC0_0000;
   localparam int          FP_SIGN_BIT = 31;

   // Subtraction is done by negating operand B before it reaches the adder.
   function automatic logic [31:0] fp_cond_negate(input logic [31:0] b, input logic sub);
      logic [31:0] r;
      r = b;
      r[FP_SIGN_BIT] = b[FP_SIGN_BIT] ^ sub;
      return r;
   endfunction

endpackage

// File: rtl/fpa_rr_pick.sv
// Combinational rotate-priority picker: first set request at or after ptr,
// wrapping to the lowest set request when none lies at or above ptr.
module fpa_rr_pick #(
   parameter int N  = 4,
   parameter int PW = 2
) (
   input  logic [N-1:0]  req,
   input  logic [PW-1:0] ptr,
   output logic [N-1:0]  gnt_onehot,
   output logic [PW-1:0] gnt_idx,
   output logic          any
);

   logic [N-1:0] hi_mask;
   logic [N-1:0] req_hi;
   logic [N-1:0] req_sel;

   generate
      for (genvar gi = 0; gi < N; gi++) begin : g_mask
         assign hi_mask[gi] = (PW'(gi) >= ptr);
      end
   endgenerate

   assign req_hi     = req & hi_mask;
   assign req_sel    = (|req_hi) ? req_hi : req;
   // Isolate the lowest set bit of the selected half.
   assign gnt_onehot = req_sel & (~req_sel + N'(1));
   assign any        = |req;

   always_comb begin
      gnt_idx = '0;
      for (int k = 0; k < N; k++) begin
         if (gnt_onehot[k]) gnt_idx = PW'(k);
      end
   end

endmodule

// File: rtl/fpa_share_arb.sv
// Round-robin sequencer sharing one fp_add_32 between N requesters.
// Optional WAIT watchdog enabled by defining FPA_ARB_TIMEOUT_EN.
module fpa_share_arb
   import fpa_arb_pkg::*;
#(
   parameter int N           = 4,
   parameter int ID_W        = 2,
   parameter int TIMEOUT_CYC = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [N-1:0]    req_valid,
   input  logic [N*32-1:0] req_a,
   input  logic [N*32-1:0] req_b,
   input  logic [N-1:0]    req_sub,
   output logic [N-1:0]    req_ready,
   output logic [N-1:0]    rsp_valid,
   output logic [ID_W-1:0] rsp_id,
   output logic [31:0]     rsp_data,
   output logic            rsp_err,
   output logic            fpu_add,
   output logic [31:0]     fpu_number1,
   output logic [31:0]     fpu_number2,
   input  logic [31:0]     fpu_result,
   input  logic            fpu_ready
);

   localparam int PW = (N > 1) ? $clog2(N) : 1;

   logic [2:0]      state_q, state_d;
   logic [2:0]      flush_q, flush_d;
   logic [PW-1:0]   ptr_q, ptr_d;
   logic [PW-1:0]   gnt_q, gnt_d;
   logic [N-1:0]    req_ready_q, req_ready_d;
   logic [N-1:0]    rsp_valid_q, rsp_valid_d;
   logic [ID_W-1:0] rsp_id_q, rsp_id_d;
   logic [31:0]     rsp_data_q, rsp_data_d;
   logic            fpu_add_q, fpu_add_d;
   logic [31:0]     num1_q, num1_d;
   logic [31:0]     num2_q, num2_d;

   logic [N-1:0]    gnt_onehot;
   logic [PW-1:0]   gnt_idx;
   logic            gnt_any;
   logic [31:0]     a_arr [N];
   logic [31:0]     b_arr [N];
   logic [31:0]     a_sel, b_sel;
   logic            sub_sel;

   fpa_rr_pick #(.N(N), .PW(PW)) u_pick (
      .req        (req_valid),
      .ptr        (ptr_q),
      .gnt_onehot (gnt_onehot),
      .gnt_idx    (gnt_idx),
      .any        (gnt_any)
   );

   generate
      for (genvar gi = 0; gi < N; gi++) begin : g_slice
         assign a_arr[gi] = req_a[32*gi +: 32];
         assign b_arr[gi] = req_b[32*gi +: 32];
      end
   endgenerate

   always_comb begin
      a_sel = '0;
      b_sel = '0;
      for (int k = 0; k < N; k++) begin
         a_sel = a_sel | (a_arr[k] & {32{gnt_onehot[k]}});
         b_sel = b_sel | (b_arr[k] & {32{gnt_onehot[k]}});
      end
   end

   assign sub_sel = |(req_sub & gnt_onehot);

`ifdef FPA_ARB_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYC + 1);
   logic [TW-1:0] to_q, to_d;
   logic          rsp_err_q, rsp_err_d;
`endif

   always_comb begin
      state_d     = state_q;
      flush_d     = flush_q;
      ptr_d       = ptr_q;
      gnt_d       = gnt_q;
      req_ready_d = '0;
      rsp_valid_d = '0;
      rsp_id_d    = rsp_id_q;
      rsp_data_d  = rsp_data_q;
      fpu_add_d   = fpu_add_q;
      num1_d      = num1_q;
      num2_d      = num2_q;
`ifdef FPA_ARB_TIMEOUT_EN
      to_d        = to_q;
      rsp_err_d   = rsp_err_q;
`endif
      case (state_q)
         ST_FLUSH: begin
            fpu_add_d = 1'b0;
            if (flush_q == 3'(FLUSH_CYC - 1)) begin
               flush_d = '0;
               state_d = ST_IDLE;
            end else begin
               flush_d = flush_q + 3'd1;
            end
         end
         ST_IDLE: begin
            if (gnt_any) begin
               num1_d      = a_sel;
               num2_d      = fp_cond_negate(b_sel, sub_sel);
               req_ready_d = gnt_onehot;
               gnt_d       = gnt_idx;
               fpu_add_d   = 1'b1;
               ptr_d       = (gnt_idx == PW'(N - 1)) ? '0 : gnt_idx + 1'b1;
               state_d     = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            // Adder has not sampled add yet, so its ready is left over from the last op.
            state_d = ST_WAIT;
`ifdef FPA_ARB_TIMEOUT_EN
            to_d    = '0;
`endif
         end
         ST_WAIT: begin
            if (fpu_ready) begin
               rsp_data_d  = fpu_result;
               rsp_id_d    = ID_W'(gnt_q);
               rsp_valid_d = {{(N-1){1'b0}}, 1'b1} << gnt_q;
               fpu_add_d   = 1'b0;
               state_d     = ST_RELEASE;
`ifdef FPA_ARB_TIMEOUT_EN
               rsp_err_d   = 1'b0;
`endif
            end
`ifdef FPA_ARB_TIMEOUT_EN
            else if (to_q == TW'(TIMEOUT_CYC - 1)) begin
               rsp_data_d  = FP_QNAN;
               rsp_id_d    = ID_W'(gnt_q);
               rsp_valid_d = {{(N-1){1'b0}}, 1'b1} << gnt_q;
               rsp_err_d   = 1'b1;
               fpu_add_d   = 1'b0;
               flush_d     = '0;
               state_d     = ST_FLUSH;
            end else begin
               to_d = to_q + 1'b1;
            end
`endif
         end
         ST_RELEASE: begin
            state_d = ST_IDLE;
         end
         default: begin
            fpu_add_d = 1'b0;
            flush_d   = '0;
            state_d   = ST_FLUSH;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_FLUSH;
         flush_q     <= '0;
         ptr_q       <= '0;
         gnt_q       <= '0;
         req_ready_q <= '0;
         rsp_valid_q <= '0;
         rsp_id_q    <= '0;
         rsp_data_q  <= '0;
         fpu_add_q   <= 1'b0;
         num1_q      <= '0;
         num2_q      <= '0;
      end else begin
         state_q     <= state_d;
         flush_q     <= flush_d;
         ptr_q       <= ptr_d;
         gnt_q       <= gnt_d;
         req_ready_q <= req_ready_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_id_q    <= rsp_id_d;
         rsp_data_q  <= rsp_data_d;
         fpu_add_q   <= fpu_add_d;
         num1_q      <= num1_d;
         num2_q      <= num2_d;
      end
   end

`ifdef FPA_ARB_TIMEOUT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         to_q      <= '0;
         rsp_err_q <= 1'b0;
      end else begin
         to_q      <= to_d;
         rsp_err_q <= rsp_err_d;
      end
   end
   assign rsp_err = rsp_err_q;
`else
   assign rsp_err = 1'b0;
`endif

   assign req_ready   = req_ready_q;
   assign rsp_valid   = rsp_valid_q;
   assign rsp_id      = rsp_id_q;
   assign rsp_data    = rsp_data_q;
   assign fpu_add     = fpu_add_q;
   assign fpu_number1 = num1_q;
   assign fpu_number2 = num2_q;

endmodule

// File: tb/tb_fpa_share_arb.sv
// Self-checking bench for fpa_share_arb with a behavioural level-handshake adder.
// Define FPA_ARB_TIMEOUT_EN to also exercise the WAIT watchdog.
module tb_fpa_share_arb;

   localparam int N = 4;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic [N-1:0]    req_valid = '0;
   logic [N*32-1:0] req_a = '0;
   logic [N*32-1:0] req_b = '0;
   logic [N-1:0]    req_sub = '0;
   logic [N-1:0]    req_ready;
   logic [N-1:0]    rsp_valid;
   logic [1:0]      rsp_id;
   logic [31:0]     rsp_data;
   logic            rsp_err;
   logic            fpu_add;
   logic [31:0]     fpu_number1;
   logic [31:0]     fpu_number2;
   logic [31:0]     fpu_result = '0;
   logic            fpu_ready = 1'b1;

   fpa_share_arb #(.N(N), .ID_W(2), .TIMEOUT_CYC(32)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .req_valid   (req_valid),
      .req_a       (req_a),
      .req_b       (req_b),
      .req_sub     (req_sub),
      .req_ready   (req_ready),
      .rsp_valid   (rsp_valid),
      .rsp_id      (rsp_id),
      .rsp_data    (rsp_data),
      .rsp_err     (rsp_err),
      .fpu_add     (fpu_add),
      .fpu_number1 (fpu_number1),
      .fpu_number2 (fpu_number2),
      .fpu_result  (fpu_result),
      .fpu_ready   (fpu_ready)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int total = 0;
   int bad = 0;

   // Adder model: known IEEE sums, otherwise a deterministic scramble.
   function automatic logic [31:0] fadd(input logic [31:0] x, input logic [31:0] y);
      if (x == 32'h3F80_0000 && y == 32'h4000_0000) return 32'h4040_0000;
      if (x == 32'h4040_0000 && y == 32'hBF80_0000) return 32'h4000_0000;
      if (x == 32'h4040_0000 && y == 32'hC040_0000) return 32'h0000_0000;
      return (x + {y[15:0], y[31:16]}) ^ 32'h5A5A_0000;
   endfunction

   // Stub adder, no reset: RDY -> BUSY (6 cycles) -> RSLT -> RDY on add low.
   int          ad_st = 0;
   int          ad_cnt = 0;
   logic [31:0] op1 = '0, op2 = '0;
   logic        hang = 1'b0;
   always @(posedge clk) begin
      case (ad_st)
         0: if (fpu_add) begin
               ad_st <= 1; ad_cnt <= 0; fpu_ready <= 1'b0;
               op1 <= fpu_number1; op2 <= fpu_number2;
            end
         1: if (!hang) begin
               if (ad_cnt == 5) begin
                  fpu_result <= fadd(op1, op2); fpu_ready <= 1'b1; ad_st <= 2;
               end else begin
                  ad_cnt <= ad_cnt + 1;
               end
            end
         default: if (!fpu_add) ad_st <= 0;
      endcase
   end

   task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   typedef struct {
      int          id;
      logic [31:0] data;
      logic        err;
      int          cyc;
   } exp_t;
   exp_t sbq[$];
   exp_t mon_e;

   always @(negedge clk) begin
      if (rst_n && $countones(req_ready) > 1) begin
         total++; bad++;
         $display("FAIL req_ready_multi: got %b expected at most one bit", req_ready);
      end
      if (rst_n && rsp_valid != '0) begin
         if (sbq.size() == 0) begin
            total++; bad++;
            $display("FAIL unexpected_rsp: got valid=%b id=%0d data=%h expected none", rsp_valid, rsp_id, rsp_data);
         end else begin
            mon_e = sbq.pop_front();
            $display("rsp id=%0d data=%h err=%b cyc=%0d", rsp_id, rsp_data, rsp_err, cyc);
            check32("rsp_valid", 32'(rsp_valid), 32'(1 << mon_e.id));
            check32("rsp_id", 32'(rsp_id), 32'(mon_e.id));
            check32("rsp_data", rsp_data, mon_e.data);
            check32("rsp_err", 32'(rsp_err), 32'(mon_e.err));
            check32("rsp_cycle", 32'(cyc), 32'(mon_e.cyc));
         end
      end
   end

   task automatic wait_ready(input int id, output bit ok);
      ok = 1'b0;
      for (int t = 0; t < 100; t++) begin
         @(negedge clk);
         if (req_ready[id]) begin ok = 1'b1; return; end
      end
      total++; bad++;
      $display("FAIL ready_timeout: got no req_ready[%0d] expected within 100 cycles", id);
   endtask

   task automatic wait_drain();
      for (int t = 0; t < 80; t++) begin
         @(negedge clk);
         if (sbq.size() == 0) return;
      end
      total++; bad++;
      $display("FAIL drain_timeout: got %0d pending expected 0", sbq.size());
      sbq.delete();
   endtask

   task automatic check_all_zero(input string tag);
      check32({tag, "_ctrl"}, 32'({req_ready, rsp_valid, rsp_id, rsp_err, fpu_add}), 32'h0);
      check32({tag, "_data"}, rsp_data, 32'h0);
      check32({tag, "_num1"}, fpu_number1, 32'h0);
      check32({tag, "_num2"}, fpu_number2, 32'h0);
   endtask

   task automatic do_req(input int id, input logic [31:0] a, input logic [31:0] b, input logic sub,
                         input logic [31:0] exp_n2, input logic [31:0] exp_d);
      bit ok;
      req_a[32*id +: 32] = a;
      req_b[32*id +: 32] = b;
      req_sub[id]        = sub;
      req_valid[id]      = 1'b1;
      wait_ready(id, ok);
      if (ok) begin
         $display("req id=%0d a=%h b=%h sub=%b cyc=%0d", id, a, b, sub, cyc);
         check32("grant_onehot", 32'(req_ready), 32'(1 << id));
         check32("fpu_number1", fpu_number1, a);
         check32("fpu_number2", fpu_number2, exp_n2);
         check32("fpu_add_issue", 32'(fpu_add), 32'h1);
         sbq.push_back('{id: id, data: exp_d, err: 1'b0, cyc: cyc + 8});
      end
      req_valid[id]      = 1'b0;
      req_a[32*id +: 32] = ~a;
      req_b[32*id +: 32] = ~b;
      if (ok) begin
         @(negedge clk);
         check32("no_rsp_after_issue", 32'(rsp_valid), 32'h0);
      end
      wait_drain();
   endtask

   typedef struct {
      int          id;
      logic [31:0] a;
      logic [31:0] b;
      logic        sub;
      logic [31:0] n2;
      logic [31:0] d;
   } vec_t;
   vec_t vecs[5];

   logic [31:0] ra[N];
   logic [31:0] rb[N];

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish expected end of test");
      $fatal(1, "watchdog");
   end

   initial begin
      bit ok;
      int last;
      int rel;
      int exp_id;

      vecs[0] = '{0, 32'h3F80_0000, 32'h4000_0000, 1'b0, 32'h4000_0000, 32'h4040_0000};
      vecs[1] = '{2, 32'h4040_0000, 32'h3F80_0000, 1'b1, 32'hBF80_0000, 32'h4000_0000};
      vecs[2] = '{1, 32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 32'h9ABC_DEF0, fadd(32'h1234_5678, 32'h9ABC_DEF0)};
      vecs[3] = '{3, 32'h4040_0000, 32'h4040_0000, 1'b1, 32'hC040_0000, 32'h0000_0000};
      vecs[4] = '{3, 32'h8000_0001, 32'h0000_0000, 1'b1, 32'h8000_0000, fadd(32'h8000_0001, 32'h8000_0000)};

      // All four requesters held from reset.
      for (int i = 0; i < N; i++) begin
         ra[i] = 32'h4000_0000 | (i * 32'h111);
         rb[i] = 32'h3F00_0000 + 32'(i);
         req_a[32*i +: 32] = ra[i];
         req_b[32*i +: 32] = rb[i];
      end
      req_valid = '1;
      repeat (3) @(negedge clk);
      check_all_zero("reset");
      rst_n = 1'b1;
      rel = cyc;
      last = rel;
      for (int k = 0; k < 5; k++) begin
         ok = 1'b0;
         for (int t = 0; t < 30; t++) begin
            @(negedge clk);
            if (|req_ready) begin ok = 1'b1; break; end
         end
         if (!ok) begin
            total++; bad++;
            $display("FAIL rr_timeout: got no grant expected grant %0d", k);
            break;
         end
         exp_id = k % N;
         $display("grant k=%0d ready=%b cyc=%0d", k, req_ready, cyc);
         check32("rr_grant", 32'(req_ready), 32'(1 << exp_id));
         check32("rr_spacing", 32'(cyc - last), (k == 0) ? 32'd8 : 32'd10);
         sbq.push_back('{id: exp_id, data: fadd(ra[exp_id], rb[exp_id]), err: 1'b0, cyc: cyc + 8});
         last = cyc;
         if (k == 4) req_valid = '0;
      end
      req_valid = '0;
      wait_drain();

      for (int i = 0; i < 5; i++)
         do_req(vecs[i].id, vecs[i].a, vecs[i].b, vecs[i].sub, vecs[i].n2, vecs[i].d);

      // Immediate re-request: ISSUE sees a stale high fpu_ready.
      do_req(vecs[0].id, vecs[0].a, vecs[0].b, vecs[0].sub, vecs[0].n2, vecs[0].d);

      // Reset while the adder is busy.
      req_a[32*1 +: 32] = 32'h1111_2222;
      req_b[32*1 +: 32] = 32'h3333_4444;
      req_valid[1] = 1'b1;
      wait_ready(1, ok);
      req_valid[1] = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check_all_zero("midrst");
      @(negedge clk);
      @(negedge clk);
      check_all_zero("midrst_hold");
      req_a[32*2 +: 32] = vecs[1].a;
      req_b[32*2 +: 32] = vecs[1].b;
      req_sub[2]        = 1'b1;
      req_valid[2]      = 1'b1;
      rst_n = 1'b1;
      for (int t = 0; t < 7; t++) begin
         @(negedge clk);
         check32("flush_quiet", 32'({fpu_add, req_ready}), 32'h0);
      end
      @(negedge clk);
      check32("post_flush_grant", 32'(req_ready), 32'h4);
      check32("post_flush_num2", fpu_number2, 32'hBF80_0000);
      if (req_ready[2]) sbq.push_back('{id: 2, data: 32'h4000_0000, err: 1'b0, cyc: cyc + 8});
      req_valid[2] = 1'b0;
      wait_drain();

`ifdef FPA_ARB_TIMEOUT_EN
      hang = 1'b1;
      req_a[32*3 +: 32] = 32'h3F80_0000;
      req_b[32*3 +: 32] = 32'h3F80_0000;
      req_sub[3]        = 1'b0;
      req_valid[3]      = 1'b1;
      wait_ready(3, ok);
      if (ok) sbq.push_back('{id: 3, data: 32'h7FC0_0000, err: 1'b1, cyc: cyc + 33});
      req_valid[3] = 1'b0;
      wait_drain();
      @(negedge clk);
      check32("timeout_flush_add", 32'(fpu_add), 32'h0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
